// File: rtl/pong_ball_renderer.sv
// pong_ball_renderer: 640x480 VGA timing generator that draws a square ball
// over a flat background. The ball position from the Nios PIO is sampled once
// per frame, so mid-frame writes never tear the image.
module pong_ball_renderer #(
   parameter int          H_ACTIVE  = 640,
   parameter int          H_FP      = 16,
   parameter int          H_SYNC    = 96,
   parameter int          H_BP      = 48,
   parameter int          V_ACTIVE  = 480,
   parameter int          V_FP      = 10,
   parameter int          V_SYNC    = 2,
   parameter int          V_BP      = 33,
   parameter int          BALL_SIZE = 8,
   parameter logic [11:0] BALL_RGB  = 12'hFFF,
   parameter logic [11:0] BG_RGB    = 12'h000
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        pix_en,
   input  logic [9:0]  ball_x,
   input  logic [9:0]  ball_y,
   output logic        vga_hs,
   output logic        vga_vs,
   output logic        vga_blank_n,
   output logic [11:0] vga_rgb,
   output logic        frame_tick
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   // Counters and ball arithmetic are 11 bits wide so ball edge sums never wrap.
   localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
   localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
   localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [10:0] BALL_W   = 11'(BALL_SIZE);

   logic [10:0] h_cnt;
   logic [10:0] v_cnt;
   logic [9:0]  bx_s;
   logic [9:0]  by_s;
   logic [10:0] bx_ext;
   logic [10:0] by_ext;
   logic        in_active;
   logic        in_hsync;
   logic        in_vsync;
   logic        ball_hit;
   logic        latch_now;
   logic [11:0] pix_rgb;

   // Raster position: h_cnt walks the line, v_cnt steps once per completed line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         h_cnt <= '0;
         v_cnt <= '0;
      end else if (pix_en) begin
         if (h_cnt == H_LAST) begin
            h_cnt <= '0;
            if (v_cnt == V_LAST) begin
               v_cnt <= '0;
            end else begin
               v_cnt <= v_cnt + 11'd1;
            end
         end else begin
            h_cnt <= h_cnt + 11'd1;
         end
      end
   end

   // Decode the current raster position into sync, active area, ball hit and colour.
   always_comb begin
      bx_ext    = {1'b0, bx_s};
      by_ext    = {1'b0, by_s};
      in_active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
      in_hsync  = (h_cnt >= HS_START) && (h_cnt < HS_END);
      in_vsync  = (v_cnt >= VS_START) && (v_cnt < VS_END);
      ball_hit  = (bx_ext < H_ACT) && (by_ext < V_ACT)
               && (h_cnt >= bx_ext) && (h_cnt < bx_ext + BALL_W)
               && (v_cnt >= by_ext) && (v_cnt < by_ext + BALL_W);
      latch_now = pix_en && (h_cnt == 11'd0) && (v_cnt == V_ACT);
      pix_rgb   = 12'h000;
      if (in_active) begin
         pix_rgb = ball_hit ? BALL_RGB : BG_RGB;
      end
   end

   // Capture the ball position at the start of vertical blanking and flag it for one clk.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bx_s       <= '0;
         by_s       <= '0;
         frame_tick <= 1'b0;
      end else begin
         frame_tick <= latch_now;
         if (latch_now) begin
            bx_s <= ball_x;
            by_s <= ball_y;
         end
      end
   end

   // Register the pixel outputs one pixel behind the counters, holding between enables.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vga_hs      <= 1'b1;
         vga_vs      <= 1'b1;
         vga_blank_n <= 1'b0;
         vga_rgb     <= 12'h000;
      end else if (pix_en) begin
         vga_hs      <= ~in_hsync;
         vga_vs      <= ~in_vsync;
         vga_blank_n <= in_active;
         vga_rgb     <= pix_rgb;
      end
   end

endmodule

// File: tb/tb_pong_ball_renderer.sv
// tb_pong_ball_renderer: scoreboard bench for pong_ball_renderer on a shrunken
// raster (40x30 visible) so several whole frames fit in a short run.
module tb_pong_ball_renderer;

   localparam int HA = 40;
   localparam int HFP = 4;
   localparam int HSY = 6;
   localparam int HBP = 6;
   localparam int HT = HA + HFP + HSY + HBP;
   localparam int VA = 30;
   localparam int VFP = 2;
   localparam int VSY = 2;
   localparam int VBP = 3;
   localparam int VT = VA + VFP + VSY + VBP;
   localparam int FRAME = HT * VT;
   localparam int BS = 8;
   localparam logic [11:0] BALL = 12'hFFF;
   localparam logic [11:0] BG = 12'h00A;

   logic        clk;
   logic        reset;
   logic        pix_en;
   logic [9:0]  ball_x;
   logic [9:0]  ball_y;
   logic        vga_hs;
   logic        vga_vs;
   logic        vga_blank_n;
   logic [11:0] vga_rgb;
   logic        frame_tick;

   typedef struct {
      logic [15:0] word;
      int          h;
      int          v;
   } exp_t;

   exp_t expQ[$];
   int   tickLog[$];
   int   vectorCount = 0;
   int   missCount = 0;
   int   clkCount = 0;
   logic lastEn = 1'b0;
   int   tbH;
   int   tbV;
   logic [9:0] sx;
   logic [9:0] sy;
   int   ballCount;
   int   blankCount;
   int   hsLowCount;
   int   vsLowCount;
   int   minX;
   int   maxX;
   int   minY;
   int   maxY;

   pong_ball_renderer #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSY), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSY), .V_BP(VBP),
      .BALL_SIZE(BS), .BALL_RGB(BALL), .BG_RGB(BG)
   ) dut (
      .clk(clk),
      .reset(reset),
      .pix_en(pix_en),
      .ball_x(ball_x),
      .ball_y(ball_y),
      .vga_hs(vga_hs),
      .vga_vs(vga_vs),
      .vga_blank_n(vga_blank_n),
      .vga_rgb(vga_rgb),
      .frame_tick(frame_tick)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Remember whether the edge just taken was an enabled pixel edge outside reset.
   always @(posedge clk) begin
      clkCount++;
      lastEn = pix_en && !reset;
   end

   task automatic checkOutput(input string name, input int actual, input int expected);
      vectorCount++;
      if (actual != expected) begin
         missCount++;
         $display("[TB] FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
                  name, actual, actual, expected, expected);
      end
   endtask

   // Monitor: after each enabled edge pop the expected pixel and compare; gather frame stats.
   always @(negedge clk) begin : monBlk
      exp_t e;
      logic [15:0] act;
      if (!reset) begin
         act = {vga_hs, vga_vs, vga_blank_n, vga_rgb, frame_tick};
         if (frame_tick) tickLog.push_back(clkCount);
         if (lastEn) begin
            if (expQ.size() == 0) begin
               checkOutput("scoreboard_empty", 1, 0);
            end else begin
               e = expQ.pop_front();
               checkOutput($sformatf("pixel h=%0d v=%0d", e.h, e.v), int'(act), int'(e.word));
               if (vga_blank_n) blankCount++;
               if (!vga_hs) hsLowCount++;
               if (!vga_vs) vsLowCount++;
               if (vga_blank_n && vga_rgb == BALL) begin
                  ballCount++;
                  if (e.h < minX) minX = e.h;
                  if (e.h > maxX) maxX = e.h;
                  if (e.v < minY) minY = e.v;
                  if (e.v > maxY) maxY = e.v;
               end
            end
         end else begin
            checkOutput("tick_idle", int'(frame_tick), 0);
         end
      end
   end

   // Reference raster: compute the pixel the DUT must show after this enabled edge.
   task automatic pushExpected();
      exp_t e;
      bit active, inBall, hsOn, vsOn, latch;
      logic [11:0] rgb;
      active = (tbH < HA) && (tbV < VA);
      hsOn   = (tbH >= HA + HFP) && (tbH < HA + HFP + HSY);
      vsOn   = (tbV >= VA + VFP) && (tbV < VA + VFP + VSY);
      inBall = (tbH >= int'(sx)) && (tbH < int'(sx) + BS)
            && (tbV >= int'(sy)) && (tbV < int'(sy) + BS);
      rgb    = !active ? 12'h000 : (inBall ? BALL : BG);
      latch  = (tbH == 0) && (tbV == VA);
      e.word = {!hsOn, !vsOn, active, rgb, latch};
      e.h    = tbH;
      e.v    = tbV;
      expQ.push_back(e);
      if (latch) begin
         sx = ball_x;
         sy = ball_y;
      end
      tbH++;
      if (tbH == HT) begin
         tbH = 0;
         tbV++;
         if (tbV == VT) tbV = 0;
      end
   endtask

   task automatic applyStimulus(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk); #1 pix_en = 1'b0;
         @(negedge clk); #1 pix_en = 1'b1;
         pushExpected();
      end
      @(negedge clk); #1 pix_en = 1'b0;
   endtask

   function automatic int edgesTo(input int v, input int h);
      int p;
      int t;
      p = tbV * HT + tbH;
      t = v * HT + h;
      return (t - p + FRAME) % FRAME;
   endfunction

   task automatic modelReset();
      tbH = 0;
      tbV = 0;
      sx  = '0;
      sy  = '0;
      expQ.delete();
   endtask

   task automatic clearStats();
      ballCount  = 0;
      blankCount = 0;
      hsLowCount = 0;
      vsLowCount = 0;
      minX = 9999;
      maxX = -1;
      minY = 9999;
      maxY = -1;
      tickLog.delete();
   endtask

   task automatic checkBall(input string tag, input int count, input int x0, input int y0, input int cols);
      checkOutput({tag, "_ball_count"}, ballCount, count);
      if (count > 0) begin
         checkOutput({tag, "_min_x"}, minX, x0);
         checkOutput({tag, "_max_x"}, maxX, x0 + cols - 1);
         checkOutput({tag, "_min_y"}, minY, y0);
         checkOutput({tag, "_max_y"}, maxY, y0 + BS - 1);
      end
   endtask

   task automatic latchBall(input int x, input int y);
      ball_x = 10'(x);
      ball_y = 10'(y);
      applyStimulus(edgesTo(VA, 0) + 1);
   endtask

   initial begin : drvBlk
      int snap;
      int changes;
      reset  = 1'b0;
      pix_en = 1'b0;
      ball_x = 10'd10;
      ball_y = 10'd5;
      modelReset();
      clearStats();
      #2 reset = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk); #1;
      checkOutput("reset_hs", int'(vga_hs), 1);
      checkOutput("reset_vs", int'(vga_vs), 1);
      checkOutput("reset_blank_n", int'(vga_blank_n), 0);
      checkOutput("reset_rgb", int'(vga_rgb), 0);
      checkOutput("reset_tick", int'(frame_tick), 0);
      reset = 1'b0;
      modelReset();
      clearStats();

      $display("[TB] hsync fall after reset release");
      applyStimulus(HA + HFP);
      checkOutput("hs_before_fall", int'(vga_hs), 1);
      applyStimulus(1);
      checkOutput("hs_fall", int'(vga_hs), 0);

      $display("[TB] two free-running frames, ball at (10,5)");
      applyStimulus(edgesTo(VA, 0) + 1);
      clearStats();
      applyStimulus(2 * FRAME);
      checkOutput("tick_count_2f", tickLog.size(), 2);
      if (tickLog.size() == 2)
         checkOutput("tick_period", tickLog[1] - tickLog[0], 2 * FRAME);
      checkOutput("blank_pixels_2f", blankCount, 2 * HA * VA);
      checkOutput("hs_low_2f", hsLowCount, 2 * HSY * VT);
      checkOutput("vs_low_2f", vsLowCount, 2 * VSY * HT);
      checkBall("two_frames", 2 * BS * BS, 10, 5, BS);

      $display("[TB] ball_x changed mid-frame at line 8");
      clearStats();
      applyStimulus(edgesTo(8, 0));
      ball_x = 10'd20;
      applyStimulus(edgesTo(VA, 0));
      checkOutput("no_tick_before_latch", tickLog.size(), 0);
      checkBall("old_frame", BS * BS, 10, 5, BS);
      clearStats();
      applyStimulus(FRAME);
      checkOutput("one_tick_per_frame", tickLog.size(), 1);
      checkBall("new_frame", BS * BS, 20, 5, BS);

      $display("[TB] ball straddling the right edge");
      latchBall(HA - 4, 5);
      clearStats();
      applyStimulus(FRAME);
      checkBall("right_edge", 4 * BS, HA - 4, 5, 4);

      $display("[TB] ball off-screen");
      latchBall(1023, 5);
      clearStats();
      applyStimulus(FRAME);
      checkBall("x_1023", 0, 0, 0, 0);
      latchBall(10, 700);
      clearStats();
      applyStimulus(FRAME);
      checkBall("y_700", 0, 0, 0, 0);

      $display("[TB] pix_en held low mid-line");
      latchBall(10, 5);
      applyStimulus(edgesTo(6, 15));
      snap = int'({vga_hs, vga_vs, vga_blank_n, vga_rgb});
      checkOutput("freeze_on_ball", int'(vga_rgb), int'(BALL));
      changes = 0;
      repeat (100) begin
         @(negedge clk); #1;
         if (int'({vga_hs, vga_vs, vga_blank_n, vga_rgb}) != snap) changes++;
      end
      checkOutput("freeze_changes", changes, 0);
      clearStats();
      applyStimulus(FRAME);
      checkOutput("resume_blank_pixels", blankCount, HA * VA);
      checkBall("resume", BS * BS, 10, 5, BS);

      $display("[TB] reset mid-frame");
      applyStimulus(edgesTo(10, 15));
      reset = 1'b1;
      #1;
      checkOutput("midreset_hs", int'(vga_hs), 1);
      checkOutput("midreset_vs", int'(vga_vs), 1);
      checkOutput("midreset_blank_n", int'(vga_blank_n), 0);
      checkOutput("midreset_rgb", int'(vga_rgb), 0);
      expQ.delete();
      repeat (3) @(posedge clk);
      @(negedge clk); #1 reset = 1'b0;
      modelReset();
      clearStats();
      applyStimulus(HA + HFP);
      checkOutput("midreset_hs_before_fall", int'(vga_hs), 1);
      applyStimulus(1);
      checkOutput("midreset_hs_fall", int'(vga_hs), 0);
      applyStimulus(edgesTo(VA, 0));
      checkBall("after_reset", BS * BS, 0, 0, BS);

      $display("== %0d vectors applied, %0d miscompares ==", vectorCount, missCount);
      $finish;
   end

   initial begin
      #1500000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
